// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing, memory-ready stalls,
// sticky illegal-opcode trap, retire counter. Define MULTICYCLE_CTRL_EXT_ISA_EN for SUBI/ANDI/XORI/SLTIU/LUI/BNE.
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_write_ne,
  output logic [1:0]          pc_src,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                lui,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [OPCODE_W-1:0] OP_R     = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
`ifdef MULTICYCLE_CTRL_EXT_ISA_EN
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(6'b001111);
  localparam logic [OPCODE_W-1:0] OP_SUBI  = OPCODE_W'(6'b110000);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b111000);
  localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(6'b111100);
  localparam logic [OPCODE_W-1:0] OP_SLTIU = OPCODE_W'(6'b111110);
`endif

  localparam logic [ALUOP_W-1:0] ALU_R    = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_BEQ  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b010);
`ifdef MULTICYCLE_CTRL_EXT_ISA_EN
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_BNE  = ALUOP_W'(3'b111);
`endif

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_REXEC,
    S_RWB,
    S_BEQ,
    S_JUMP,
    S_TRAP
`ifdef MULTICYCLE_CTRL_EXT_ISA_EN
    ,
    S_BNE,
    S_IEXEC,
    S_IWB,
    S_LUIWB
`endif
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [OPCODE_W-1:0] op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q <= opcode;
      end
      if (state == S_DECODE && next_state == S_TRAP) begin
        illegal <= 1'b1;
      end
      if (instr_done) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  // Everything is forced idle while reset is high so an aborted access drops immediately.
  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_write_ne   = 1'b0;
    pc_src        = 2'd0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    lui           = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          case (opcode)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_R:         next_state = S_REXEC;
            OP_BEQ:       next_state = S_BEQ;
            OP_J:         next_state = S_JUMP;
`ifdef MULTICYCLE_CTRL_EXT_ISA_EN
            OP_BNE:       next_state = S_BNE;
            OP_LUI:       next_state = S_LUIWB;
            OP_SUBI, OP_ANDI, OP_XORI, OP_SLTIU: next_state = S_IEXEC;
`endif
            default:      next_state = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'd2;
          next_state = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            next_state = S_MEMWB;
          end
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            next_state = S_FETCH;
          end
        end
        S_REXEC: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_R;
          next_state = S_RWB;
        end
        S_RWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a     = 1'b1;
          pc_src        = 2'd1;
          alu_op        = ALU_BEQ;
          pc_write_cond = 1'b1;
          instr_done    = 1'b1;
          next_state    = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_TRAP: begin
          next_state = S_TRAP;
        end
`ifdef MULTICYCLE_CTRL_EXT_ISA_EN
        S_BNE: begin
          alu_src_a   = 1'b1;
          pc_src      = 2'd1;
          alu_op      = ALU_BNE;
          pc_write_ne = 1'b1;
          instr_done  = 1'b1;
          next_state  = S_FETCH;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          // op_q was latched in DECODE, so the instruction register may move on.
          case (op_q)
            OP_ANDI:  alu_op = ALU_AND;
            OP_XORI:  alu_op = ALU_XOR;
            OP_SLTIU: alu_op = ALU_SLTU;
            default:  alu_op = ALU_SUB;
          endcase
          next_state = S_IWB;
        end
        S_IWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_LUIWB: begin
          lui        = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
`endif
        default: begin
          next_state = S_FETCH;
        end
      endcase
    end
  end

endmodule
